// File: rtl/euler_step_sequencer_if.sv
// Handshake bundle between the host/core side and the Euler step sequencer.
// The master modport is the sequencer; the slave modport is its environment.
interface euler_step_sequencer_if #(
    parameter int DATA_SIZE = 16,
    parameter int CNT_SIZE  = 16
);
    logic                 cmd_start;
    logic [DATA_SIZE-1:0] cfg_h;
    logic [DATA_SIZE-1:0] cfg_t_end;
    logic                 core_finish;
    logic                 core_error;
    logic                 core_start;
    logic [DATA_SIZE-1:0] h_step;
    logic [DATA_SIZE-1:0] t_now;
    logic [CNT_SIZE-1:0]  step_count;
    logic                 busy;
    logic                 done;
    logic                 error;
    logic [1:0]           err_code;

    modport master (
        input  cmd_start, cfg_h, cfg_t_end, core_finish, core_error,
        output core_start, h_step, t_now, step_count, busy, done, error, err_code
    );

    modport slave (
        output cmd_start, cfg_h, cfg_t_end, core_finish, core_error,
        input  core_start, h_step, t_now, step_count, busy, done, error, err_code
    );
endinterface

// File: rtl/euler_step_sequencer.sv
// Drives the Euler core from t=0 to t_end, clipping the final step onto t_end
// and halving h to retry a step the core reports as failed.
module euler_step_sequencer #(
    parameter int DATA_SIZE = 16,
    parameter int CNT_SIZE  = 16,
    parameter int TIMEOUT   = 1024,
    parameter int MAX_RETRY = 3
) (
    input logic                    clk,
    input logic                    rst,
    euler_step_sequencer_if.master bus
);
    // state | meaning
    // IDLE  | no run since reset
    // ISSUE | present clipped h_step, pulse core_start
    // WAIT  | wait for core_finish, timeout timer running
    // CHECK | accept the step, or halve h and retry
    // DONE  | t_now reached t_end, results held
    // ERR   | run aborted, err_code held
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [2:0] {
        ST_IDLE, ST_ISSUE, ST_WAIT, ST_CHECK, ST_DONE, ST_ERR
    } state_t;

    state_t               state_q, state_d;
    logic [DATA_SIZE-1:0] h_q, h_d;
    logic [DATA_SIZE-1:0] t_end_q, t_end_d;
    logic [DATA_SIZE-1:0] t_now_q, t_now_d;
    logic [DATA_SIZE-1:0] h_step_q, h_step_d;
    logic [CNT_SIZE-1:0]  step_q, step_d;
    logic [RW-1:0]        retry_q, retry_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic                 core_err_q, core_err_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;
    logic [1:0]           err_code_q, err_code_d;

    logic [DATA_SIZE-1:0] remain;
    logic [DATA_SIZE-1:0] issue_step;
    logic [DATA_SIZE-1:0] t_sum;

    // Clipping uses a local copy so h itself only shrinks on error retries.
    assign remain     = t_end_q - t_now_q;
    assign issue_step = (h_q < remain) ? h_q : remain;
    assign t_sum      = t_now_q + h_step_q;

    always_comb begin
        state_d    = state_q;
        h_d        = h_q;
        t_end_d    = t_end_q;
        t_now_d    = t_now_q;
        h_step_d   = h_step_q;
        step_d     = step_q;
        retry_d    = retry_q;
        timer_d    = timer_q;
        core_err_d = core_err_q;
        done_d     = done_q;
        error_d    = error_q;
        err_code_d = err_code_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (bus.cmd_start) begin
                    h_d        = bus.cfg_h;
                    t_end_d    = bus.cfg_t_end;
                    t_now_d    = '0;
                    h_step_d   = '0;
                    step_d     = '0;
                    retry_d    = '0;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    err_code_d = 2'b00;
                    if (bus.cfg_h == '0 || bus.cfg_t_end == '0) begin
                        error_d    = 1'b1;
                        err_code_d = 2'b11;
                        state_d    = ST_ERR;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                h_step_d = issue_step;
                timer_d  = '0;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.core_finish) begin
                    core_err_d = bus.core_error;
                    state_d    = ST_CHECK;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    error_d    = 1'b1;
                    err_code_d = 2'b10;
                    state_d    = ST_ERR;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_CHECK: begin
                if (!core_err_q) begin
                    t_now_d = t_sum;
                    step_d  = step_q + CNT_SIZE'(1);
                    retry_d = '0;
                    if (t_sum == t_end_q) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end else if (retry_q < RW'(MAX_RETRY) && h_q > DATA_SIZE'(1)) begin
                    h_d     = h_q >> 1;
                    retry_d = retry_q + RW'(1);
                    state_d = ST_ISSUE;
                end else begin
                    error_d    = 1'b1;
                    err_code_d = 2'b01;
                    state_d    = ST_ERR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            h_q        <= '0;
            t_end_q    <= '0;
            t_now_q    <= '0;
            h_step_q   <= '0;
            step_q     <= '0;
            retry_q    <= '0;
            timer_q    <= '0;
            core_err_q <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            h_q        <= h_d;
            t_end_q    <= t_end_d;
            t_now_q    <= t_now_d;
            h_step_q   <= h_step_d;
            step_q     <= step_d;
            retry_q    <= retry_d;
            timer_q    <= timer_d;
            core_err_q <= core_err_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
        end
    end

    // h_step is live in ISSUE and held from the register through WAIT and after.
    assign bus.core_start = (state_q == ST_ISSUE);
    assign bus.h_step     = (state_q == ST_ISSUE) ? issue_step : h_step_q;
    assign bus.t_now      = t_now_q;
    assign bus.step_count = step_q;
    assign bus.busy       = (state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_CHECK);
    assign bus.done       = done_q;
    assign bus.error      = error_q;
    assign bus.err_code   = err_code_q;
endmodule

// File: tb/tb_euler_step_sequencer.sv
// Bench for euler_step_sequencer: a behavioural core model plus a step-list
// reference computed per run, checked at every core_start and at run end.
module tb_euler_step_sequencer;
    localparam int TIMEOUT   = 1024;
    localparam int MAX_RETRY = 3;

    logic clk;
    logic rst;

    euler_step_sequencer_if #(.DATA_SIZE(16), .CNT_SIZE(16)) bus ();

    euler_step_sequencer #(
        .DATA_SIZE(16), .CNT_SIZE(16), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_pulse = 0;
    int last_pulse_cyc = 0;
    int err_rise_cyc = 0;
    int att_cnt = 0;
    int base = 0;
    int lat_min = 5;
    int lat_max = 5;
    bit hang = 0;
    bit err_pat [1024];

    logic [15:0] exp_h [$];
    logic [15:0] exp_t [$];

    int          m_code;
    int          m_n;
    int          m_att;
    logic [15:0] m_t;
    bit          m_done;
    bit          m_fin;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic set_err(input int pct);
        for (int i = 0; i < 1024; i++) err_pat[i] = ($urandom_range(0, 99) < pct);
    endtask

    // Reference: walk the attempts arithmetically, producing the step list.
    task automatic model(input logic [15:0] h, input logic [15:0] te);
        logic [15:0] mh, s;
        int r;
        exp_h.delete();
        exp_t.delete();
        m_code = 0; m_n = 0; m_att = 0; m_t = '0; m_done = 0; mh = h; r = 0;
        if (h == 0 || te == 0) begin
            m_code = 3;
        end else if (hang) begin
            s = (h < te) ? h : te;
            exp_h.push_back(s);
            exp_t.push_back(16'h0);
            m_att = 1;
            m_code = 2;
        end else begin
            while (m_code == 0 && !m_done && m_att < 200) begin
                s = (mh < te - m_t) ? mh : te - m_t;
                exp_h.push_back(s);
                exp_t.push_back(m_t);
                if (err_pat[m_att]) begin
                    if (r < MAX_RETRY && mh > 1) begin
                        mh = mh >> 1;
                        r++;
                    end else begin
                        m_code = 1;
                    end
                end else begin
                    m_t = m_t + s;
                    m_n++;
                    r = 0;
                    if (m_t == te) m_done = 1;
                end
                m_att++;
            end
        end
        m_fin = m_done || (m_code != 0);
    endtask

    task automatic do_reset();
        bus.cmd_start = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_core_start"}, bus.core_start, 0);
        chk({tag, "_h_step"}, bus.h_step, 0);
        chk({tag, "_t_now"}, bus.t_now, 0);
        chk({tag, "_step_count"}, bus.step_count, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_error"}, bus.error, 0);
        chk({tag, "_err_code"}, bus.err_code, 0);
    endtask

    task automatic run(input logic [15:0] h, input logic [15:0] te, input bit poke);
        int p0, w;
        model(h, te);
        p0 = n_pulse;
        base = att_cnt;
        bus.cfg_h = h;
        bus.cfg_t_end = te;
        bus.cmd_start = 1'b1;
        @(posedge clk); #1;
        bus.cmd_start = 1'b0;
        bus.cfg_h = 16'($urandom);
        bus.cfg_t_end = 16'($urandom);
        if (poke && m_code != 3) begin
            @(posedge clk); #1;
            bus.cmd_start = 1'b1;
            @(posedge clk); #1;
            bus.cmd_start = 1'b0;
        end
        w = 0;
        while (!(bus.done || bus.error) && w < 4000) begin
            @(posedge clk); #1;
            w++;
        end
        if (w >= 4000) begin
            checks++;
            errors++;
            $display("FAIL run_end no done/error within 4000 cycles h=%0h t_end=%0h", h, te);
        end
        chk("end_done", bus.done, m_done);
        chk("end_error", bus.error, (m_code != 0));
        chk("end_err_code", bus.err_code, m_code);
        chk("end_t_now", bus.t_now, m_t);
        chk("end_step_count", bus.step_count, m_n);
        chk("end_busy", bus.busy, 0);
        chk("end_pulses", n_pulse - p0, m_att);
        chk("end_steps_left", exp_h.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_done", bus.done, m_done);
        chk("hold_err_code", bus.err_code, m_code);
        chk("hold_t_now", bus.t_now, m_t);
        if (m_code == 2) chk("timeout_latency", err_rise_cyc - last_pulse_cyc, TIMEOUT + 1);
    endtask

    // Behavioural core: finish rises a few cycles after start, cleared by the start edge.
    initial begin : core_model
        bit pend;
        bit act;
        int cnt;
        int idx;
        bus.core_finish = 1'b0;
        bus.core_error = 1'b0;
        act = 0; cnt = 0; idx = 0;
        forever begin
            @(negedge clk);
            pend = bus.core_start;
            @(posedge clk); #1;
            if (rst) begin
                act = 0;
                bus.core_finish = 1'b0;
                bus.core_error = 1'b0;
            end else if (pend) begin
                bus.core_finish = 1'b0;
                bus.core_error = 1'b0;
                cnt = $urandom_range(lat_max, lat_min);
                idx = (att_cnt - base) & 1023;
                att_cnt++;
                act = 1;
            end else if (act && !hang) begin
                if (cnt <= 1) begin
                    bus.core_finish = 1'b1;
                    bus.core_error = err_pat[idx];
                    act = 0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Per-cycle compare: every core_start must carry the next modelled step.
    initial begin : compare
        logic prev_fin, prev_err;
        int ref_cyc, ref_off;
        logic [15:0] eh, et;
        prev_fin = 1'b0; prev_err = 1'b0; ref_cyc = 0; ref_off = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                if (bus.cmd_start && !bus.busy) begin
                    ref_cyc = cyc;
                    ref_off = 1;
                end
                if (bus.core_finish && !prev_fin && bus.busy && !bus.core_start) begin
                    ref_cyc = cyc;
                    ref_off = 2;
                end
                if (bus.error && !prev_err) err_rise_cyc = cyc;
                if (bus.core_start) begin
                    n_pulse++;
                    last_pulse_cyc = cyc;
                    if (exp_h.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL pulse_expected core_start with no step left h_step=%0h", bus.h_step);
                    end else begin
                        eh = exp_h.pop_front();
                        et = exp_t.pop_front();
                        chk("issue_h_step", bus.h_step, eh);
                        chk("issue_t_now", bus.t_now, et);
                        chk("issue_latency", cyc - ref_cyc, ref_off);
                        chk("issue_busy", bus.busy, 1);
                    end
                end
            end
            prev_fin = bus.core_finish;
            prev_err = bus.error;
        end
    end

    initial begin : stimulus
        int p0, w;
        logic [15:0] h, te;
        bus.cmd_start = 1'b0;
        bus.cfg_h = '0;
        bus.cfg_t_end = '0;
        rst = 1'b1;
        do_reset();
        chk_zero("reset");

        set_err(0); lat_min = 5; lat_max = 5;
        p0 = n_pulse;
        run(16'h0100, 16'h0300, 0);
        chk("t1_steps", bus.step_count, 3);
        chk("t1_t_now", bus.t_now, 16'h0300);
        chk("t1_pulses", n_pulse - p0, 3);

        p0 = n_pulse;
        run(16'h0100, 16'h0280, 1);
        chk("t2_steps", bus.step_count, 3);
        chk("t2_t_now", bus.t_now, 16'h0280);
        chk("t2_pulses", n_pulse - p0, 3);

        set_err(0); err_pat[0] = 1; err_pat[1] = 1;
        p0 = n_pulse;
        run(16'h0100, 16'h0100, 0);
        chk("t3_steps", bus.step_count, 4);
        chk("t3_t_now", bus.t_now, 16'h0100);
        chk("t3_pulses", n_pulse - p0, 6);

        set_err(100);
        p0 = n_pulse;
        run(16'h0010, 16'h0100, 0);
        chk("t4_pulses", n_pulse - p0, 4);
        chk("t4_err_code", bus.err_code, 1);
        chk("t4_steps", bus.step_count, 0);

        set_err(0); hang = 1;
        p0 = n_pulse;
        run(16'h0040, 16'h0100, 0);
        chk("t5_pulses", n_pulse - p0, 1);
        chk("t5_err_code", bus.err_code, 2);
        hang = 0;
        do_reset();

        lat_min = 20; lat_max = 20;
        exp_h.delete(); exp_t.delete();
        exp_h.push_back(16'h0100); exp_t.push_back(16'h0000);
        p0 = n_pulse;
        bus.cfg_h = 16'h0100; bus.cfg_t_end = 16'h0300; bus.cmd_start = 1'b1;
        @(posedge clk); #1;
        bus.cmd_start = 1'b0;
        w = 0;
        while (n_pulse == p0 && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("t6_busy_before_rst", bus.busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_zero("t6_rst");
        exp_h.delete(); exp_t.delete();
        p0 = n_pulse;
        run(16'h0000, 16'h0100, 0);
        chk("t6_err_code", bus.err_code, 3);
        chk("t6_pulses", n_pulse - p0, 0);

        for (int k = 0; k < 25; k++) begin
            h  = 16'($urandom_range(16, 1024));
            te = 16'(int'(h) * $urandom_range(0, 4) + $urandom_range(1, int'(h)));
            if ($urandom_range(0, 9) == 0) h = 16'h0;
            lat_min = $urandom_range(1, 3);
            lat_max = lat_min + $urandom_range(0, 3);
            set_err($urandom_range(0, 30));
            model(h, te);
            if (!m_fin) set_err(0);
            run(h, te, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
